// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding for the digit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter width for N slices; never narrower than one bit so N=1 still has a counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// rtl/serial_adder_digit.sv - combinational DIGIT-bit ripple adder of full-adder cells
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract with registered result and flags
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]       cnt;
  logic                   carry;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       acc;
  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co;
  logic                   last;
  logic [WIDTH+DIGIT-1:0] acc_ext;
  logic [WIDTH-1:0]       acc_nxt;

  assign last = (cnt == LAST);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New slice enters at the top of the accumulator; after N shifts slice 0 sits at the LSB.
  assign acc_ext = {slice_s, acc};
  assign acc_nxt = acc_ext[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= slice_co;
          acc   <= acc_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            // On the final slice the operand MSBs are the top bits of the current digit.
            sum  <= acc_nxt;
            cout <= slice_co;
            ovf  <= (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (slice_s[DIGIT-1] != a_sh[DIGIT-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at DIGIT 1, 4 and 16
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] sum_w  [3];
  logic        cout_w [3];
  logic        ovf_w  [3];

  int          checks   = 0;
  int          failures = 0;
  int          ns [3]   = '{16, 4, 1};
  logic [17:0] prev [3];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views; returns {cout, ovf, sum}.
  function automatic logic [17:0] model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = int'($signed(x));
    int   sy = int'($signed(y));
    int   ci = c ? 1 : 0;
    int   u;
    int   r;
    logic co;
    if (!s) begin
      u  = ux + uy + ci;
      r  = sx + sy + ci;
      co = (u > 65535);
    end else begin
      u  = ux - uy - ci;
      r  = sx - sy - ci;
      co = (u >= 0);
    end
    return {co, (r > 32767) || (r < -32768), u[15:0]};
  endfunction

  // One operation on the DUTs selected by mask; optionally a stray start at RUN cycle 2.
  task automatic run_op(input logic [2:0] mask, input logic s, input logic [15:0] x,
                        input logic [15:0] y, input logic c, input logic [2:0] inj);
    logic [17:0] exp;
    logic [17:0] got [3];
    int          lat [3];
    int          nd  [3];
    exp = model(s, x, y, c);
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0;
      nd[j]  = 0;
      got[j] = '0;
    end
    @(negedge clk);
    a = x; b = y; sub = s; cin = c; st = mask;
    @(posedge clk);
    #1;
    st = 3'b000; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        if (mask[j]) begin
          if (k <= ns[j]) check($sformatf("busy_d%0d_k%0d", j, k), 32'(busy_w[j]), 32'(k < ns[j]));
          if (k < ns[j]) check($sformatf("hold_d%0d_k%0d", j, k), 32'(sum_w[j]), 32'(prev[j][15:0]));
          if (done_w[j]) begin
            nd[j]++;
            if (lat[j] == 0) begin
              lat[j] = k;
              got[j] = {cout_w[j], ovf_w[j], sum_w[j]};
            end
          end
        end
      end
      if (k == 2 && inj != 3'b000) begin
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; st = inj;
      end else begin
        st = 3'b000;
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (mask[j]) begin
        check($sformatf("lat_d%0d", j), 32'(lat[j]), 32'(ns[j]));
        check($sformatf("ndone_d%0d", j), 32'(nd[j]), 32'd1);
        check($sformatf("res_d%0d", j), 32'(got[j]), 32'(exp));
        check($sformatf("stable_d%0d", j), 32'({cout_w[j], ovf_w[j], sum_w[j]}), 32'(exp));
        prev[j] = exp;
      end
    end
  endtask

  initial begin
    int t0;
    int t1;
    int nd;
    logic [17:0] exp;
    rst_n = 1'b0; st = 3'b000; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    for (int j = 0; j < 3; j++) prev[j] = '0;
    #3;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_out_d%0d", j),
            32'({busy_w[j], done_w[j], cout_w[j], ovf_w[j], sum_w[j]}), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b111, 1'b0, 16'h0001, 16'hFFFF, 1'b0, 3'b000);
    run_op(3'b111, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 3'b000);
    run_op(3'b111, 1'b1, 16'h0005, 16'h0007, 1'b0, 3'b000);
    run_op(3'b111, 1'b0, 16'h1234, 16'h4321, 1'b1, 3'b000);
    run_op(3'b011, 1'b0, 16'h0002, 16'h0003, 1'b0, 3'b011);
    run_op(3'b111, 1'b1, 16'h8000, 16'h0001, 1'b1, 3'b000);

    for (int r = 0; r < 24; r++) begin
      run_op(3'b111, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 3'b000);
    end

    // Start held high on the DIGIT=4 instance: accepts again in IDLE right after DONE.
    exp = model(1'b1, 16'h0100, 16'h0FFF, 1'b0);
    @(negedge clk);
    a = 16'h0100; b = 16'h0FFF; sub = 1'b1; cin = 1'b0; st = 3'b010;
    t0 = 0; t1 = 0; nd = 0;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done_w[1]) begin
        nd++;
        if (t0 == 0) t0 = k; else if (t1 == 0) t1 = k;
        check($sformatf("b2b_res_k%0d", k), 32'({cout_w[1], ovf_w[1], sum_w[1]}), 32'(exp));
      end
    end
    st = 3'b000;
    check("b2b_first", 32'(t0), 32'd4);
    check("b2b_second", 32'(t1), 32'd10);
    check("b2b_count", 32'(nd), 32'd2);
    repeat (8) @(posedge clk);
    prev[1] = exp;

    // Reset during RUN: outputs clear without a clock edge, and no done follows.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; st = 3'b001;
    @(posedge clk);
    #1;
    st = 3'b000;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("abort_out_d%0d", j),
            32'({busy_w[j], done_w[j], cout_w[j], ovf_w[j], sum_w[j]}), 32'd0);
      prev[j] = '0;
    end
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0] || busy_w[0]) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    run_op(3'b111, 1'b0, 16'h0010, 16'h0020, 1'b0, 3'b000);
    check("post_rst_sum", 32'(sum_w[0]), 32'h0030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle; legal values divide WIDTH exactly.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract; latched with start.
REQ-007 SHALL have port a  input  WIDTH  operand A, latched with start.
REQ-008 SHALL have port b  input  WIDTH  operand B, latched with start.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub), latched with start.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port sum  output  WIDTH  registered result.
REQ-013 SHALL have port cout  output  1  carry-out (add) / not-borrow (sub).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE with start=1 at a rising edge, latch a, b XOR {WIDTH{sub}}, carry = cin XOR sub, clear the digit counter, and enter RUN.
REQ-017 SHALL, in RUN, add one DIGIT-bit slice per cycle, LSB slice first, carrying between slices through a 1-bit carry register.
REQ-018 SHALL take exactly N = WIDTH/DIGIT RUN cycles; on the edge completing slice N-1, load sum, cout, ovf and enter DONE.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-020 SHALL make done first visible N edges after the edge that sampled start.
REQ-021 SHALL compute sum = (a + b + cin) mod 2^WIDTH for add, and (a - b - cin) mod 2^WIDTH for sub.
REQ-022 SHALL set ovf = (A_msb == B'_msb) AND (sum_msb != A_msb), with B' the latched, possibly inverted, operand.
REQ-023 SHALL hold sum, cout and ovf stable from load until the next completion; intermediate slices SHALL NOT appear on sum.
REQ-024 SHALL ignore start in RUN and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-025 SHALL accept a start held high continuously back-to-back: first in IDLE, next in IDLE after DONE.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state IDLE, counter 0, carry 0, busy 0, done 0, sum 0, cout 0, ovf 0, independent of clk.
REQ-027 SHALL abort an in-progress RUN on reset with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Structure
REQ-028 SHALL place the FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) in shared package serial_adder_pkg.
REQ-029 SHALL instantiate one sub-module digit_adder: DIGIT-bit ripple adder built from full-adder cells, inputs x, y, ci, outputs s, co, purely combinational.
REQ-030 SHALL keep counter width $clog2(N) with a minimum of 1 bit, and handle DIGIT=WIDTH (N=1) correctly.

Verification (WIDTH=16)
REQ-031 SHALL cover DIGIT=1, add 0x0001+0xFFFF, cin=0 -> sum 0x0000, cout 1, ovf 0, done 16 edges after start.
REQ-032 SHALL cover DIGIT=1, add 0x7FFF+0x0001, cin=0 -> sum 0x8000, cout 0, ovf 1.
REQ-033 SHALL cover DIGIT=1, sub 0x0005-0x0007, cin=0 -> sum 0xFFFE, cout 0, ovf 0.
REQ-034 SHALL cover DIGIT=4, add 0x1234+0x4321, cin=1 -> sum 0x5556, cout 0, done 4 edges after start.
REQ-035 SHALL cover a start pulse with a=0x00FF, b=0x0001 during busy of a prior 0x0002+0x0003 -> sum 0x0005, exactly one done.
REQ-036 SHALL cover rst_n pulsed low in RUN cycle 5 -> all outputs 0 immediately, no done; a following 0x0010+0x0020 -> 0x0030.
